cpu_trace_emitter: RTL
======================

CPU_TRACE_EMITTER -- requirements
Module: cpu_trace_emitter

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, all state updates on posedge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, trace record offered.
REQ-004 SHALL have port in_ready, output, 1, record accepted on this posedge when in_valid high.
REQ-005 SHALL have port in_is_mem, input, 1, 0 = register write record, 1 = memory write record.
REQ-006 SHALL have port in_time, input, 14, time stamp, unsigned.
REQ-007 SHALL have port in_pc, input, 32, instruction address.
REQ-008 SHALL have port in_grf, input, 5, register number, used when in_is_mem=0.
REQ-009 SHALL have port in_addr, input, 32, memory address, used when in_is_mem=1.
REQ-010 SHALL have port in_data, input, 32, written value.
REQ-011 SHALL have port char, output, 8, ASCII character, 8'h00 when char_valid low.
REQ-012 SHALL have port char_valid, output, 1, char holds a stream character.
REQ-013 SHALL have port char_ready, input, 1, consumer takes char on posedge when char_valid high.

Function
REQ-014 SHALL accept a record when in_valid && in_ready; all in_* fields latched at that edge.
REQ-015 SHALL drive in_ready high in IDLE, and in HASH when char_ready is high; low otherwise.
REQ-016 SHALL emit register format: '^' time '@' pc ':' ' ' '$' grf ' ' '<' '=' ' ' data '#'.
REQ-017 SHALL emit memory format: identical except '*' followed by addr in place of '$' grf.
REQ-018 SHALL print time in decimal, leading zeros suppressed, minimum one digit; values above 9999 clamp to 9999.
REQ-019 SHALL print grf in decimal, one or two digits, leading zeros suppressed.
REQ-020 SHALL print pc, addr, data as exactly 8 lowercase hex digits, MSB nibble first.
REQ-021 SHALL use states IDLE, CARET, TIME, AT, PC, COLON, SP1, MARK, IDX, SP2, LT, EQ, SP3, DATA, HASH; digit counter per multi-char field.
REQ-022 SHALL advance state only on posedge with char_valid && char_ready; otherwise hold char and char_valid unchanged.
REQ-023 SHALL present '^' in the cycle after acceptance (latency 1); one character per accepted cycle thereafter.
REQ-024 SHALL, on acceptance in HASH, move directly to CARET so back-to-back records have no gap.
REQ-025 SHALL return HASH -> IDLE with char_valid low when no new record is accepted.
REQ-026 SHALL ignore in_valid while in_ready is low; fields change only at acceptance.

Reset
REQ-027 SHALL on reset, at any time including mid-record, force IDLE, char_valid=0, char=8'h00, in_ready=1 after release, counters and latched fields zero.
REQ-028 SHALL discard any partially emitted record on reset; no '#' emitted for it.

Configuration
REQ-029 SHALL, with TRACE_SPACE_EN defined, emit states SP1, SP2, SP3 (one space each).
REQ-030 SHALL, without TRACE_SPACE_EN, skip SP1/SP2/SP3 entirely (compact form "…:$3<=…").

Structure
REQ-031 SHALL place state enum, ASCII constants ('^','@',':','$','*','<','=','#',' '), and time clamp limit 9999 in shared package cpu_trace_pkg.
REQ-032 SHALL instantiate one combinational sub-module trace_bin2bcd (14-bit to four BCD digits, double-dabble) for time and grf conversion.

Verification
REQ-033 SHALL cover: reg record time=10, pc=0x00003000, grf=3, data=0xa, char_ready=1, spaces on -> "^10@00003000: $3 <= 0000000a#", 29 chars, then char_valid low.
REQ-034 SHALL cover: mem record time=0, pc=0x00003004, addr=0x00000010, data=0xdeadbeef -> "^0@00003004: *00000010 <= deadbeef#".
REQ-035 SHALL cover: time=12000, grf=31 -> time printed "9999", grf printed "31".
REQ-036 SHALL cover: two records with in_valid held high -> '#' of first immediately followed by '^' of second, no idle cycle.
REQ-037 SHALL cover: char_ready low for 3 cycles during PC field -> same hex digit held 4 cycles, stream content unchanged.
REQ-038 SHALL cover: reset asserted mid-DATA field -> char_valid low immediately, next accepted record starts with '^'.

Source files
------------

// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU trace emitter: FSM states, ASCII glyphs, time clamp
// and small character-formatting helpers. TRACE_SPACE_EN selects the spaced output form.
package cpu_trace_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        CARET = 4'd1,
        TIME  = 4'd2,
        AT    = 4'd3,
        PC    = 4'd4,
        COLON = 4'd5,
        SP1   = 4'd6,
        MARK  = 4'd7,
        IDX   = 4'd8,
        SP2   = 4'd9,
        LT    = 4'd10,
        EQ    = 4'd11,
        SP3   = 4'd12,
        DATA  = 4'd13,
        HASH  = 4'd14
    } trace_state_e;

    localparam logic [7:0] CH_CARET  = 8'h5e;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3a;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2a;
    localparam logic [7:0] CH_LT     = 8'h3c;
    localparam logic [7:0] CH_EQ     = 8'h3d;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_ZERO   = 8'h30;
    localparam logic [7:0] CH_NUL    = 8'h00;
    // 'a' minus ten, so nibble 10 maps to 'a'
    localparam logic [7:0] HEX_ALPHA_BASE = 8'h57;

    localparam logic [13:0] TIME_CLAMP = 14'd9999;
    localparam logic [2:0]  HEX_MSN    = 3'd7;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] ch;
        if (nib < 4'd10) begin
            ch = CH_ZERO + {4'h0, nib};
        end else begin
            ch = HEX_ALPHA_BASE + {4'h0, nib};
        end
        return ch;
    endfunction

    function automatic logic [7:0] dec_ascii(input logic [3:0] digit);
        return CH_ZERO + {4'h0, digit};
    endfunction

    function automatic logic [3:0] nibble_at(input logic [31:0] word, input logic [2:0] idx);
        return word[{idx, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] digit_at(input logic [15:0] bcd, input logic [1:0] idx);
        return bcd[{idx, 2'b00} +: 4];
    endfunction

    // Index of the most significant non-zero BCD digit; zero keeps one digit
    function automatic logic [1:0] msd_index(input logic [15:0] bcd);
        logic [1:0] idx;
        if (bcd[15:12] != 4'd0) begin
            idx = 2'd3;
        end else if (bcd[11:8] != 4'd0) begin
            idx = 2'd2;
        end else if (bcd[7:4] != 4'd0) begin
            idx = 2'd1;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

    function automatic trace_state_e after_colon();
`ifdef TRACE_SPACE_EN
        return SP1;
`else
        return MARK;
`endif
    endfunction

    function automatic trace_state_e after_idx();
`ifdef TRACE_SPACE_EN
        return SP2;
`else
        return LT;
`endif
    endfunction

    function automatic trace_state_e after_eq();
`ifdef TRACE_SPACE_EN
        return SP3;
`else
        return DATA;
`endif
    endfunction

endpackage

// File: rtl/cpu_trace_emitter_if.sv
// Record-in / character-out handshake bundle for the CPU trace emitter.
interface cpu_trace_emitter_if;

    logic        in_valid;
    logic        in_ready;
    logic        in_is_mem;
    logic [13:0] in_time;
    logic [31:0] in_pc;
    logic [4:0]  in_grf;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [7:0]  char;
    logic        char_valid;
    logic        char_ready;

    modport master (
        output in_valid, in_is_mem, in_time, in_pc, in_grf, in_addr, in_data, char_ready,
        input  in_ready, char, char_valid
    );

    modport slave (
        input  in_valid, in_is_mem, in_time, in_pc, in_grf, in_addr, in_data, char_ready,
        output in_ready, char, char_valid
    );

endinterface

// File: rtl/trace_bin2bcd.sv
// Combinational 14-bit binary to four-digit BCD converter (double-dabble).
module trace_bin2bcd (
    input  logic [13:0] bin,
    output logic [15:0] bcd
);

    logic [29:0] scratch;

    // Shift-and-add-3 over all fourteen input bits
    always_comb begin
        scratch = {16'h0000, bin};
        for (int i = 0; i < 14; i++) begin
            for (int d = 0; d < 4; d++) begin
                scratch[14 + 4*d +: 4] = (scratch[14 + 4*d +: 4] > 4'd4) ?
                                         scratch[14 + 4*d +: 4] + 4'd3 :
                                         scratch[14 + 4*d +: 4];
            end
            scratch = {scratch[28:0], 1'b0};
        end
        bcd = scratch[29:14];
    end

endmodule

// File: rtl/cpu_trace_emitter.sv
// Serialises register/memory write trace records into an ASCII character stream.
// Define TRACE_SPACE_EN to include the three separating spaces in each record.
module cpu_trace_emitter
    import cpu_trace_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    cpu_trace_emitter_if.slave   bus
);

    trace_state_e state_r, state_next;
    logic [2:0]   cnt_r, cnt_next;
    logic [7:0]   char_r, char_next;
    logic         char_valid_r, char_valid_next;

    logic         is_mem_r;
    logic [13:0]  time_r;
    logic [31:0]  pc_r;
    logic [4:0]   grf_r;
    logic [31:0]  addr_r;
    logic [31:0]  data_r;

    logic         in_ready_s;
    logic         accept_s;
    logic         advance_s;
    logic         last_s;
    logic [13:0]  bcd_bin_s;
    logic [15:0]  bcd_s;

    assign in_ready_s = (state_r == IDLE) || ((state_r == HASH) && bus.char_ready);
    assign accept_s   = bus.in_valid && in_ready_s;
    assign advance_s  = char_valid_r && bus.char_ready;
    assign last_s     = (cnt_r == 3'd0);

    assign bus.in_ready   = in_ready_s;
    assign bus.char       = char_r;
    assign bus.char_valid = char_valid_r;

    // The converter serves the register index while it is being announced or printed
    assign bcd_bin_s = (((state_r == MARK) || (state_r == IDX)) && !is_mem_r) ?
                       {9'd0, grf_r} : time_r;

    trace_bin2bcd u_bin2bcd (
        .bin (bcd_bin_s),
        .bcd (bcd_s)
    );

    // Next-state selection; every move except acceptance waits for a taken character
    always_comb begin
        state_next = state_r;
        case (state_r)
            IDLE:    state_next = accept_s ? CARET : IDLE;
            CARET:   state_next = advance_s ? TIME : CARET;
            TIME:    state_next = (advance_s && last_s) ? AT : TIME;
            AT:      state_next = advance_s ? PC : AT;
            PC:      state_next = (advance_s && last_s) ? COLON : PC;
            COLON:   state_next = advance_s ? after_colon() : COLON;
            SP1:     state_next = advance_s ? MARK : SP1;
            MARK:    state_next = advance_s ? IDX : MARK;
            IDX:     state_next = (advance_s && last_s) ? after_idx() : IDX;
            SP2:     state_next = advance_s ? LT : SP2;
            LT:      state_next = advance_s ? EQ : LT;
            EQ:      state_next = advance_s ? after_eq() : EQ;
            SP3:     state_next = advance_s ? DATA : SP3;
            DATA:    state_next = (advance_s && last_s) ? HASH : DATA;
            HASH: begin
                if (accept_s) begin
                    state_next = CARET;
                end else if (advance_s) begin
                    state_next = IDLE;
                end else begin
                    state_next = HASH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Digit counter and the character that goes with the next state
    always_comb begin
        cnt_next = cnt_r;
        if (state_next != state_r) begin
            case (state_next)
                TIME:    cnt_next = {1'b0, msd_index(bcd_s)};
                PC:      cnt_next = HEX_MSN;
                IDX:     cnt_next = is_mem_r ? HEX_MSN : {1'b0, msd_index(bcd_s)};
                DATA:    cnt_next = HEX_MSN;
                default: cnt_next = 3'd0;
            endcase
        end else if (advance_s) begin
            cnt_next = cnt_r - 3'd1;
        end else begin
            cnt_next = cnt_r;
        end

        char_valid_next = (state_next != IDLE);
        case (state_next)
            IDLE:    char_next = CH_NUL;
            CARET:   char_next = CH_CARET;
            TIME:    char_next = dec_ascii(digit_at(bcd_s, cnt_next[1:0]));
            AT:      char_next = CH_AT;
            PC:      char_next = hex_ascii(nibble_at(pc_r, cnt_next));
            COLON:   char_next = CH_COLON;
            SP1:     char_next = CH_SPACE;
            MARK:    char_next = is_mem_r ? CH_STAR : CH_DOLLAR;
            IDX:     char_next = is_mem_r ? hex_ascii(nibble_at(addr_r, cnt_next)) :
                                            dec_ascii(digit_at(bcd_s, cnt_next[1:0]));
            SP2:     char_next = CH_SPACE;
            LT:      char_next = CH_LT;
            EQ:      char_next = CH_EQ;
            SP3:     char_next = CH_SPACE;
            DATA:    char_next = hex_ascii(nibble_at(data_r, cnt_next));
            HASH:    char_next = CH_HASH;
            default: char_next = CH_NUL;
        endcase
    end

    // FSM, counter and registered character outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= 3'd0;
            char_r       <= CH_NUL;
            char_valid_r <= 1'b0;
        end else begin
            state_r      <= state_next;
            cnt_r        <= cnt_next;
            char_r       <= char_next;
            char_valid_r <= char_valid_next;
        end
    end

    // Record fields are captured only on acceptance; time is clamped on the way in
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_mem_r <= 1'b0;
            time_r   <= 14'd0;
            pc_r     <= 32'h0000_0000;
            grf_r    <= 5'd0;
            addr_r   <= 32'h0000_0000;
            data_r   <= 32'h0000_0000;
        end else if (accept_s) begin
            is_mem_r <= bus.in_is_mem;
            time_r   <= (bus.in_time > TIME_CLAMP) ? TIME_CLAMP : bus.in_time;
            pc_r     <= bus.in_pc;
            grf_r    <= bus.in_grf;
            addr_r   <= bus.in_addr;
            data_r   <= bus.in_data;
        end else begin
            is_mem_r <= is_mem_r;
            time_r   <= time_r;
            pc_r     <= pc_r;
            grf_r    <= grf_r;
            addr_r   <= addr_r;
            data_r   <= data_r;
        end
    end

endmodule
